// File: rtl/number_adder_seq.sv
// number_adder_seq: wide (32*WORDS-bit) add sequenced through one 32-bit adder, LS word first.
// Define NUMBER_ADDER_SEQ_SUB_EN to add a 'sub' port that turns the operation into a - b.

module number_adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};
endmodule

module number_adder_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*WORDS-1:0]  a,
    input  logic [32*WORDS-1:0]  b,
    input  logic                 cin,
`ifdef NUMBER_ADDER_SEQ_SUB_EN
    input  logic                 sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*WORDS-1:0]  sum,
    output logic                 cout,
    output logic                 busy
);
    localparam int N    = 32 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [N-1:0]      r_a;
    logic [N-1:0]      r_b;
    logic [N-1:0]      r_sum;
    logic              r_carry;
    logic              r_cout;
    logic              r_sub;
    logic [IDXW-1:0]   r_idx;
    logic [31:0]       w_aWord;
    logic [31:0]       w_bRaw;
    logic [31:0]       w_bWord;
    logic [31:0]       w_addSum;
    logic              w_addCout;
    logic              w_lastWord;
    logic              w_subIn;

`ifdef NUMBER_ADDER_SEQ_SUB_EN
    assign w_subIn = sub;
`else
    assign w_subIn = 1'b0;
`endif

    always_comb begin
        w_aWord = '0;
        w_bRaw  = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_aWord = r_a[32*k +: 32];
                w_bRaw  = r_b[32*k +: 32];
            end
        end
    end

    // Subtraction is a + ~b + 1; the +1 comes from the carry seeded at accept.
    assign w_bWord    = r_sub ? ~w_bRaw : w_bRaw;
    assign w_lastWord = (r_idx == IDXW'(WORDS - 1));

    number_adder u_adder (
        .i_a    (w_aWord),
        .i_b    (w_bWord),
        .i_cin  (r_carry),
        .o_sum  (w_addSum),
        .o_cout (w_addCout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid)   w_nextState = ADD;
            ADD:     if (w_lastWord) w_nextState = DONE;
            DONE:    if (out_ready)  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_sub   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sub   <= w_subIn;
                        r_carry <= w_subIn | cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                    end
                end
                ADD: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (r_idx == IDXW'(k)) begin
                            r_sum[32*k +: 32] <= w_addSum;
                        end
                    end
                    r_carry <= w_addCout;
                    if (w_lastWord) begin
                        r_cout <= w_addCout;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
endmodule

// File: tb/tb_number_adder_seq.sv
// Directed self-checking bench for number_adder_seq with WORDS=4 (128-bit operands).
// Subtract vectors are exercised when NUMBER_ADDER_SEQ_SUB_EN is defined.

module tb_number_adder_seq;
    localparam int WORDS = 4;
    localparam int N     = 32 * WORDS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
`ifdef NUMBER_ADDER_SEQ_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    number_adder_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef NUMBER_ADDER_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request on a negedge, lets the next posedge accept it, then scrambles the inputs.
    task automatic applyStimulus(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tcin);
        @(negedge clk);
        checkOutput("in_ready_before_accept", {{(N-1){1'b0}}, in_ready}, 128'd1);
        a        = ta;
        b        = tb;
        cin      = tcin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb;
        cin      = ~tcin;
`ifdef NUMBER_ADDER_SEQ_SUB_EN
        sub      = ~sub;
`endif
    endtask

    task automatic waitDone(input string tag);
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            checkOutput({tag, "_busy"}, {{(N-1){1'b0}}, busy}, 128'd1);
        end
        checkOutput({tag, "_latency"}, N'(cyc), 128'd5);
    endtask

    task automatic checkResult(input string tag, input logic [N-1:0] expSum, input logic expCout);
        checkOutput({tag, "_sum"}, sum, expSum);
        checkOutput({tag, "_cout"}, {{(N-1){1'b0}}, cout}, {{(N-1){1'b0}}, expCout});
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_ov_cleared"}, {{(N-1){1'b0}}, out_valid}, 128'd0);
        checkOutput({tag, "_in_ready"}, {{(N-1){1'b0}}, in_ready}, 128'd1);
        checkOutput({tag, "_idle"}, {{(N-1){1'b0}}, busy}, 128'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
`ifdef NUMBER_ADDER_SEQ_SUB_EN
        sub       = 1'b0;
`endif

        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", {{(N-1){1'b0}}, out_valid}, 128'd0);
        checkOutput("reset_busy", {{(N-1){1'b0}}, busy}, 128'd0);
        checkOutput("reset_sum", sum, 128'd0);
        checkOutput("reset_cout", {{(N-1){1'b0}}, cout}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_in_ready", {{(N-1){1'b0}}, in_ready}, 128'd1);

        applyStimulus(128'd0, 128'd0, 1'b0);
        waitDone("zero");
        checkResult("zero", 128'd0, 1'b0);
        consume("zero");

        applyStimulus({128{1'b1}}, 128'd1, 1'b0);
        waitDone("ripple");
        checkResult("ripple", 128'd0, 1'b1);
        consume("ripple");

        applyStimulus(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0);
        waitDone("xword");
        checkResult("xword", 128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0);
        consume("xword");

        applyStimulus(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                      128'h1111_1111_1111_1111_1111_1111_1111_1111, 1'b0);
        waitDone("mixed");
        checkResult("mixed", 128'h1234_5678_9ABC_DF01_0FED_CBA9_8765_4321, 1'b0);
        consume("mixed");

        applyStimulus(128'h8000_0000_0000_0000_0000_0000_0000_0000,
                      128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
        waitDone("topcarry");
        checkResult("topcarry", 128'd0, 1'b1);
        consume("topcarry");

        // Result held under backpressure while a competing request is offered.
        applyStimulus(128'h1234, 128'h1, 1'b0);
        waitDone("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", {{(N-1){1'b0}}, out_valid}, 128'd1);
            checkOutput("bp_in_ready", {{(N-1){1'b0}}, in_ready}, 128'd0);
            checkResult("bp_hold", 128'h1235, 1'b0);
            a        = {128{1'b1}};
            b        = {128{1'b1}};
            cin      = 1'b1;
            in_valid = (i == 1);
        end
        consume("bp");

        applyStimulus(128'hAB, 128'hCD, 1'b1);
        waitDone("cin");
        checkResult("cin", 128'h179, 1'b0);
        consume("cin");

        // Asynchronous reset in the middle of ADD, after word 0 has been written.
        applyStimulus({128{1'b1}}, 128'd0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("partial_word0", sum, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_add_out_valid", {{(N-1){1'b0}}, out_valid}, 128'd0);
        checkOutput("rst_add_busy", {{(N-1){1'b0}}, busy}, 128'd0);
        checkOutput("rst_add_sum", sum, 128'd0);
        checkOutput("rst_add_cout", {{(N-1){1'b0}}, cout}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_add_in_ready", {{(N-1){1'b0}}, in_ready}, 128'd1);
        checkOutput("rst_add_no_residual", {{(N-1){1'b0}}, out_valid}, 128'd0);

        // Asynchronous reset while a result sits in DONE.
        applyStimulus({128{1'b1}}, {128{1'b1}}, 1'b1);
        waitDone("done_rst");
        checkResult("done_rst_pre", {128{1'b1}}, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_done_out_valid", {{(N-1){1'b0}}, out_valid}, 128'd0);
        checkOutput("rst_done_sum", sum, 128'd0);
        checkOutput("rst_done_cout", {{(N-1){1'b0}}, cout}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_0000_0000, 128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0);
        waitDone("recover");
        checkResult("recover", 128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0);
        consume("recover");

`ifdef NUMBER_ADDER_SEQ_SUB_EN
        sub = 1'b1;
        applyStimulus(128'd5, 128'd3, 1'b0);
        waitDone("sub_pos");
        checkResult("sub_pos", 128'd2, 1'b1);
        consume("sub_pos");

        sub = 1'b1;
        applyStimulus(128'd3, 128'd5, 1'b1);
        waitDone("sub_neg");
        checkResult("sub_neg", {{127{1'b1}}, 1'b0}, 1'b0);
        consume("sub_neg");

        sub = 1'b0;
        applyStimulus(128'd5, 128'd3, 1'b0);
        waitDone("sub_off");
        checkResult("sub_off", 128'd8, 1'b0);
        consume("sub_off");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
